button_conditioner: RTL and testbench

Front-end stage between the four raw player push-buttons and button_decoder.
- Synchronises each asynchronous button input and debounces it.
- Emits a single-cycle one-hot press pulse per debounced rising edge on btn_pulse[3:0], which drives button_decoder.btn directly.
- Also exports the stable debounced levels, used for LED echo and for hold detection by the game FSM.

---
 rtl/button_conditioner_pkg.sv | 28 ++
 rtl/button_conditioner_channel.sv | 83 ++++++++
 rtl/button_conditioner.sv | 51 +++++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//
// Shared definitions for the Simon button front end.
//   - NUM_BTNS                : number of player push-buttons.
//   - btn_idx_e               : button bit order. Bit 0..3 carry colour 0..3.
//                               button_decoder uses the same order for its val
//                               mapping, so btn_pulse can feed it directly.
//   - DEFAULT_DEBOUNCE_CYCLES : 10 ms at 50 MHz.
//   - cnt_width()             : width of a counter that must hold 0..cycles.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    localparam int NUM_BTNS                = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        BTN_COLOUR0 = 2'd0,
        BTN_COLOUR1 = 2'd1,
        BTN_COLOUR2 = 2'd2,
        BTN_COLOUR3 = 2'd3
    } btn_idx_e;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One button channel. It has a two-flop synchroniser, a debounce counter, the
// debounced level and a one-cycle press pulse.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset; clears every flop
//   raw    in   raw button level, asynchronous to clk (1 = pressed)
//   en     in   press-pulse enable; only gates pulse
//   level  out  registered debounced level
//   pulse  out  registered one-cycle pulse on each debounced 0->1 transition
//
// The level flips on the DEBOUNCE_CYCLES-th consecutive edge at which the
// synchronised input differs from it. Any edge where they agree restarts the
// count.
// -----------------------------------------------------------------------------
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES   // legal range >= 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic en,
    output logic level,
    output logic pulse
);

    localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q,    s1_d;
    logic             s2_q,    s2_d;
    logic             lvl_q,   lvl_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // This is the last mismatching edge, so the level flips now. A
            // flip towards 1 is a press. The press is only reported when en is
            // high in this cycle. A press is never queued for later.
            lvl_d   = s2_q;
            cnt_d   = '0;
            pulse_d = s2_q & en;
        end else begin
            // Unreachable when DEBOUNCE_CYCLES == 1, because CNT_MAX is then 0.
            // The counter resets on flip, so it stays at or below CNT_MAX.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = lvl_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the four raw player push-buttons. Each button gets its own
// synchroniser and debouncer. btn_pulse carries a one-cycle pulse per
// debounced press and feeds button_decoder.btn directly.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_raw    in   [3:0] raw button levels, asynchronous (1 = pressed)
//   en         in   press-pulse enable; 0 suppresses btn_pulse only
//   btn_pulse  out  [3:0] registered one-cycle press pulses
//   btn_level  out  [3:0] registered debounced levels
//   any_held   out  1 when any debounced level is 1
//
// Presses that complete on the same edge produce a multi-hot pulse. This block
// does not arbitrate between them; button_decoder rejects that cycle.
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES   // legal range >= 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                en,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic                any_held
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .en    (en),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    // any_held is computed only from the level flops. It therefore changes on
    // the same edge as btn_level and always agrees with it.
    assign any_held = |btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with DEBOUNCE_CYCLES=4.
// The reference model keeps, per button, the run of synchronised samples seen
// since the last level flip. The level flips once the latest DEBOUNCE_CYCLES
// samples all disagree with it.
module tb_button_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_pulse;
    logic [3:0] btn_level;
    logic       any_held;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .en        (en),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .any_held  (any_held)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] raw_hist[$];     // raw samples taken at past edges
    logic       run_q[4][$];     // synced samples since the last flip, per button
    logic [3:0] m_lvl   = 4'b0;
    logic [3:0] m_pulse = 4'b0;
    int         tally[4];        // pulses observed per button

    function automatic void model_reset();
        raw_hist.delete();
        for (int i = 0; i < 4; i++) run_q[i].delete();
        m_lvl   = 4'b0;
        m_pulse = 4'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] raw_in, input logic en_in);
        logic [3:0] synced;
        logic       flip;
        // The input seen by the debouncer is the raw value from two edges earlier.
        synced = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 4'b0000;
        raw_hist.push_back(raw_in);
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        m_pulse = 4'b0;
        for (int i = 0; i < 4; i++) begin
            run_q[i].push_back(synced[i]);
            if (run_q[i].size() > DC) void'(run_q[i].pop_front());
            flip = (run_q[i].size() == DC);
            foreach (run_q[i][k]) if (run_q[i][k] == m_lvl[i]) flip = 1'b0;
            if (flip) begin
                if (!m_lvl[i] && en_in) m_pulse[i] = 1'b1;
                m_lvl[i] = ~m_lvl[i];
                run_q[i].delete();
            end
        end
    endfunction

    // One clock: capture the inputs before the edge, advance the model, then
    // compare all outputs 1 time unit after the edge.
    task automatic step();
        logic [3:0] r;
        logic       e, rs;
        r = btn_raw; e = en; rs = rst;
        @(posedge clk); #1;
        if (rs) model_reset();
        else    model_edge(r, e);
        chk("level",    {28'b0, btn_level}, {28'b0, m_lvl});
        chk("pulse",    {28'b0, btn_pulse}, {28'b0, m_pulse});
        chk("any_held", {31'b0, any_held},  {31'b0, |m_lvl});
        for (int i = 0; i < 4; i++) tally[i] += int'(btn_pulse[i]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 4; i++) tally[i] = 0;
    endtask

    // Raise rst between edges and check that the outputs clear without a clock.
    task automatic async_rst(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_level"}, {28'b0, btn_level}, 32'h0);
        chk({tag, "_pulse"}, {28'b0, btn_pulse}, 32'h0);
        chk({tag, "_held"},  {31'b0, any_held},  32'h0);
    endtask

    initial begin
        clear_tally();

        // Reset with all buttons down, before any clock edge.
        #1;
        btn_raw = 4'b1111;
        async_rst("rst0");
        run(2);
        rst = 1'b0;
        btn_raw = 4'b0000;
        run(20);
        chk("idle_pulses", 32'(tally[0] + tally[1] + tally[2] + tally[3]), 32'd0);

        // Clean press, then release.
        en = 1'b1;
        clear_tally();
        btn_raw = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 5) chk("press_lvl_e5", {28'b0, btn_level}, 32'h0);
            if (k == 6) chk("press_pulse_e6", {28'b0, btn_pulse}, 32'h1);
            if (k == 7) chk("press_pulse_e7", {28'b0, btn_pulse}, 32'h0);
        end
        chk("press_held", {31'b0, any_held}, 32'h1);
        btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 5) chk("rel_lvl_e5", {28'b0, btn_level}, 32'h1);
            if (k == 6) chk("rel_lvl_e6", {28'b0, btn_level}, 32'h0);
        end
        chk("press_count", 32'(tally[0]), 32'd1);

        // Bouncing button 2, then held.
        clear_tally();
        for (int k = 0; k < 12; k++) begin
            btn_raw[2] = ((k / 2) % 2 == 0);
            step();
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 6) chk("bounce_pulse_e6", {28'b0, btn_pulse}, 32'h4);
        end
        chk("bounce_count", 32'(tally[2]), 32'd1);
        btn_raw = 4'b0000;
        run(10);

        // A 3-cycle glitch must not change the level.
        btn_raw[1] = 1'b1;
        run(3);
        btn_raw[1] = 1'b0;
        run(10);
        chk("glitch_level", {28'b0, btn_level}, 32'h0);

        // Two buttons pressed in the same cycle.
        btn_raw = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) chk("simul_pulse", {28'b0, btn_pulse}, 32'h3);
        end
        btn_raw = 4'b0000;
        run(10);

        // Enable gating.
        clear_tally();
        en = 1'b0;
        btn_raw = 4'b1000;
        run(10);
        chk("en0_level", {28'b0, btn_level}, 32'h8);
        en = 1'b1;
        run(10);
        chk("en_rise_nopulse", 32'(tally[3]), 32'd0);
        btn_raw = 4'b0000;
        run(10);
        btn_raw = 4'b1000;
        run(10);
        chk("en_repress", 32'(tally[3]), 32'd1);
        btn_raw = 4'b0000;
        run(10);

        // Async reset while all levels are high.
        btn_raw = 4'b1111;
        run(10);
        async_rst("rst_hi");
        run(1);
        rst = 1'b0;
        btn_raw = 4'b0000;
        run(10);

        // Reset in the middle of a count, with the button still held afterwards.
        clear_tally();
        btn_raw = 4'b0010;
        run(3);
        async_rst("rst_mid");
        run(1);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) chk("post_rst_pulse", {28'b0, btn_pulse}, 32'h2);
        end
        chk("post_rst_count", 32'(tally[1]), 32'd1);
        btn_raw = 4'b0000;
        run(10);

        // Randomised activity: bouncing inputs, enable changes and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 599) == 0) begin
                async_rst("rst_rand");
                run(1);
                rst = 1'b0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
